sdp_ram_init: RTL and testbench

//  Simple dual-port SRAM (one write port, one read port, one clock) with per-byte write enables,

---
 rtl/sdp_ram_pkg.sv | 40 ++++
 rtl/sdp_ram_rd_pipe.sv | 55 +++++
 rtl/sdp_ram_init.sv | 192 +++++++++++++++++++
 tb/tb_sdp_ram_init.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// ----------------------------------------------------------------------------
// sdp_ram_pkg
//   Shared types and helpers for the sdp_ram_init storage primitive.
//   - sdp_ram_state_e : INIT while the fill sequencer owns the write port,
//                       READY once user traffic is accepted.
//   - be_merge()      : byte-lane merge of a new word over an old word. The
//                       same merge is used for the array write update and for
//                       the same-address read bypass, so the two paths cannot
//                       disagree on which bytes a partial write touches.
//   The merge operates on a fixed maximum width. Callers zero-extend their
//   operands and truncate the result back to their own DATA_WIDTH.
// ----------------------------------------------------------------------------
package sdp_ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sdp_ram_state_e;

    localparam int MAX_DATA_WIDTH = 512;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    // Bytes whose enable bit is set come from new_word, all others from
    // old_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_WIDTH; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sdp_ram_rd_pipe.sv
// ----------------------------------------------------------------------------
// sdp_ram_rd_pipe
//   Read-return pipeline of RD_LATENCY register stages (1 or 2), each holding
//   a valid bit and a data word. A data register only loads when its incoming
//   valid is high, so the final stage keeps presenting the last returned word
//   between reads. Synchronous active-low reset clears valid and data in every
//   stage, which drops any read still in flight.
//
//   Ports
//     clk        in   1           clock, rising edge
//     rst_n      in   1           synchronous active-low reset
//     in_valid   in   1           read accepted this cycle
//     in_data    in   DATA_WIDTH  word looked up for that read
//     out_valid  out  1           read return strobe
//     out_data   out  DATA_WIDTH  read return data, held while out_valid=0
// ----------------------------------------------------------------------------
module sdp_ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [RD_LATENCY-1:0] stage_valid;
    logic [DATA_WIDTH-1:0] stage_data [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            stage_valid[0] <= in_valid;
            if (in_valid) begin
                stage_data[0] <= in_data;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                if (stage_valid[i-1]) begin
                    stage_data[i] <= stage_data[i-1];
                end
            end
        end
    end

    assign out_valid = stage_valid[RD_LATENCY-1];
    assign out_data  = stage_data[RD_LATENCY-1];

endmodule

// File: rtl/sdp_ram_init.sv
// ----------------------------------------------------------------------------
// sdp_ram_init
//   Simple dual-port RAM: one write port with per-byte enables and one read
//   port on a single clock. After reset an init sequencer writes INIT_VALUE
//   to every word, one word per cycle, so users see a known memory image
//   without a software clear. User requests are ignored while it runs.
//
//   Handshake: there is no backpressure. In READY a read is accepted on every
//   cycle I_RdEn is high and returns exactly one O_RdValid pulse RD_LATENCY
//   cycles later; a write is committed at the edge where I_WrEn is high.
//   O_RdData only changes together with O_RdValid (or on reset).
//
//   Ports
//     I_Clk       in   1           clock, rising edge
//     I_Rst_n     in   1           synchronous active-low reset
//     I_WrEn      in   1           write request
//     I_WrAddr    in   ADDR_WIDTH  write address
//     I_WrData    in   DATA_WIDTH  write data
//     I_WrBe      in   BE_WIDTH    byte enables, bit i gates I_WrData[8i+7:8i]
//     I_RdEn      in   1           read request
//     I_RdAddr    in   ADDR_WIDTH  read address
//     O_RdData    out  DATA_WIDTH  read data, qualified by O_RdValid
//     O_RdValid   out  1           one pulse per accepted read
//     O_InitBusy  out  1           high while the init sequencer runs
// ----------------------------------------------------------------------------
module sdp_ram_init
    import sdp_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    RAM_DEPTH  = 64,
    parameter int                    RD_LATENCY = 1,
    parameter int                    BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                   ADDR_WIDTH = $clog2(RAM_DEPTH),
    localparam int                   BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  I_Clk,
    input  logic                  I_Rst_n,
    input  logic                  I_WrEn,
    input  logic [ADDR_WIDTH-1:0] I_WrAddr,
    input  logic [DATA_WIDTH-1:0] I_WrData,
    input  logic [BE_WIDTH-1:0]   I_WrBe,
    input  logic                  I_RdEn,
    input  logic [ADDR_WIDTH-1:0] I_RdAddr,
    output logic [DATA_WIDTH-1:0] O_RdData,
    output logic                  O_RdValid,
    output logic                  O_InitBusy
);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("sdp_ram_init: DATA_WIDTH must be a multiple of 8 and <= %0d", MAX_DATA_WIDTH);
    end
    if (RAM_DEPTH < 2) begin : g_bad_depth
        $error("sdp_ram_init: RAM_DEPTH must be at least 2");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sdp_ram_init: RD_LATENCY must be 1 or 2");
    end

    // Depth expressed one bit wider than an address so the range compare
    // works for power-of-two depths as well.
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);

    // ------------------------------------------------------------------
    // Storage. Not reset: the init sequence overwrites every word.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    // ------------------------------------------------------------------
    // Init FSM and fill counter. O_InitBusy is registered alongside the
    // state so it drops on the first READY cycle.
    // ------------------------------------------------------------------
    sdp_ram_state_e        state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_busy;

    always_ff @(posedge I_Clk) begin
        if (!I_Rst_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_busy <= 1'b1;
        end else if (state == INIT) begin
            if (init_cnt == LAST_ADDR) begin
                state     <= READY;
                init_cnt  <= '0;
                init_busy <= 1'b0;
            end else begin
                init_cnt  <= init_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    assign O_InitBusy = init_busy;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic is_ready;
    logic wr_in_range;
    logic rd_in_range;
    logic user_wr;
    logic user_rd;
    logic collision;

    assign is_ready    = (state == READY);
    assign wr_in_range = ({1'b0, I_WrAddr} < DEPTH_LIMIT);
    assign rd_in_range = ({1'b0, I_RdAddr} < DEPTH_LIMIT);

    // Out-of-range writes are silently dropped; out-of-range reads still
    // return a valid strobe, with zero data.
    assign user_wr   = is_ready && I_WrEn && wr_in_range;
    assign user_rd   = is_ready && I_RdEn;
    assign collision = I_WrEn && (I_WrAddr == I_RdAddr);

    // ------------------------------------------------------------------
    // Write port mux: the sequencer owns the port during INIT, the user
    // port afterwards. Nothing is written on a reset edge.
    // ------------------------------------------------------------------
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BE_WIDTH-1:0]   mem_wbe;
    logic [DATA_WIDTH-1:0] mem_wword;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_cnt;
        mem_wdata = INIT_VALUE;
        mem_wbe   = '1;
        if (I_Rst_n) begin
            if (!is_ready) begin
                mem_we = 1'b1;
            end else begin
                mem_we    = user_wr;
                mem_waddr = I_WrAddr;
                mem_wdata = I_WrData;
                mem_wbe   = I_WrBe;
            end
        end
    end

    assign mem_wword = DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(mem[mem_waddr]),
                                            MAX_DATA_WIDTH'(mem_wdata),
                                            MAX_BE_WIDTH'(mem_wbe)));

    always_ff @(posedge I_Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wword;
        end
    end

    // ------------------------------------------------------------------
    // Read lookup. The array is read before this edge's write lands, so
    // without bypass a same-address read sees the old word. With bypass the
    // pending write is merged over the old word so the read sees the bytes
    // that are about to be stored.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (BYPASS != 0 && collision) begin
                rd_word = DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(mem[I_RdAddr]),
                                               MAX_DATA_WIDTH'(I_WrData),
                                               MAX_BE_WIDTH'(I_WrBe)));
            end else begin
                rd_word = mem[I_RdAddr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return pipeline
    // ------------------------------------------------------------------
    sdp_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (I_Clk),
        .rst_n     (I_Rst_n),
        .in_valid  (user_rd),
        .in_data   (rd_word),
        .out_valid (O_RdValid),
        .out_data  (O_RdData)
    );

endmodule

// File: tb/tb_sdp_ram_init.sv
// ----------------------------------------------------------------------------
// tb_sdp_ram_init
//   Two instances share one stimulus stream:
//     dut 0 : depth 64, read latency 1, bypass on,  init A5A5_A5A5
//     dut 1 : depth 48, read latency 2, bypass off, init 0F0F_3C3C
//   Depth 48 exercises out-of-range addresses (48..63) on a 6-bit address.
//   The driver keeps a word-array model per instance and pushes the expected
//   read word plus its due edge into a queue; a monitor pops on every
//   O_RdValid and compares data and timing, and checks hold/reset behaviour.
// ----------------------------------------------------------------------------
module tb_sdp_ram_init;

    localparam int DW = 32;
    localparam int AW = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] rd_data [2];
    logic          rd_valid [2];
    logic          init_busy [2];

    sdp_ram_init #(
        .DATA_WIDTH (32), .RAM_DEPTH (64), .RD_LATENCY (1), .BYPASS (1),
        .INIT_VALUE (32'hA5A5_A5A5)
    ) dut_a (
        .I_Clk (clk), .I_Rst_n (rst_n),
        .I_WrEn (wr_en), .I_WrAddr (wr_addr), .I_WrData (wr_data), .I_WrBe (wr_be),
        .I_RdEn (rd_en), .I_RdAddr (rd_addr),
        .O_RdData (rd_data[0]), .O_RdValid (rd_valid[0]), .O_InitBusy (init_busy[0])
    );

    sdp_ram_init #(
        .DATA_WIDTH (32), .RAM_DEPTH (48), .RD_LATENCY (2), .BYPASS (0),
        .INIT_VALUE (32'h0F0F_3C3C)
    ) dut_b (
        .I_Clk (clk), .I_Rst_n (rst_n),
        .I_WrEn (wr_en), .I_WrAddr (wr_addr), .I_WrData (wr_data), .I_WrBe (wr_be),
        .I_RdEn (rd_en), .I_RdAddr (rd_addr),
        .O_RdData (rd_data[1]), .O_RdValid (rd_valid[1]), .O_InitBusy (init_busy[1])
    );

    // ---------------- per-instance configuration ----------------
    function automatic int depth_of(input int d);
        return (d == 0) ? 64 : 48;
    endfunction
    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction
    function automatic bit byp_of(input int d);
        return (d == 0);
    endfunction
    function automatic logic [DW-1:0] init_of(input int d);
        return (d == 0) ? 32'hA5A5_A5A5 : 32'h0F0F_3C3C;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [3:0]    be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q [2][$];
    int            due_q [2][$];
    logic [DW-1:0] mdl [2][64];
    int            since_rel [2];
    int            valid_seen [2];
    logic [DW-1:0] last_data [2];
    int            edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- model step + one clock ----------------
    // Called at a negedge with the inputs for the coming edge already driven.
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                since_rel[d] = 0;
                exp_q[d].delete();
                due_q[d].delete();
                for (int a = 0; a < 64; a++) mdl[d][a] = init_of(d);
            end else if (since_rel[d] < depth_of(d)) begin
                since_rel[d]++;
            end else begin
                if (rd_en) begin
                    logic [DW-1:0] e;
                    if (int'(rd_addr) >= depth_of(d))
                        e = '0;
                    else if (byp_of(d) && wr_en && wr_addr == rd_addr)
                        e = merge(mdl[d][rd_addr], wr_data, wr_be);
                    else
                        e = mdl[d][rd_addr];
                    exp_q[d].push_back(e);
                    due_q[d].push_back(edge_cnt + lat_of(d));
                end
                if (wr_en && int'(wr_addr) < depth_of(d))
                    mdl[d][wr_addr] = merge(mdl[d][wr_addr], wr_data, wr_be);
            end
        end
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [3:0] be, input logic re, input logic [AW-1:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        tick();
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 4'h0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) idle();
        rst_n = 1'b1;
    endtask

    // Counts busy-high cycles from reset release; optionally pokes a write
    // and read at addr 3 while the sequencer runs.
    task automatic count_busy(input bit poke);
        int na, nb;
        na = 0; nb = 0;
        for (int i = 0; i < 80; i++) begin
            if (init_busy[0] === 1'b1) na++;
            if (init_busy[1] === 1'b1) nb++;
            if (poke && i == 2) drive(1'b1, 6'd3, 32'h1234_5678, 4'hF, 1'b1, 6'd3);
            else idle();
        end
        checks++;
        if (na != 64) begin
            errors++;
            $display("FAIL busy_len dut0 got %0d cycles, required 64", na);
        end
        checks++;
        if (nb != 48) begin
            errors++;
            $display("FAIL busy_len dut1 got %0d cycles, required 48", nb);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) idle();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [DW-1:0] e;
        int            due;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (rst_n !== 1'b1) begin
                    checks++;
                    if (rd_valid[d] !== 1'b0 || rd_data[d] !== '0) begin
                        errors++;
                        $display("FAIL reset_out dut%0d valid=%b data=%h, required valid=0 data=0",
                                 d, rd_valid[d], rd_data[d]);
                    end
                    last_data[d] = '0;
                end else if (rd_valid[d] === 1'b1) begin
                    valid_seen[d]++;
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid dut%0d data=%h at edge %0d, required no valid",
                                 d, rd_data[d], edge_cnt);
                    end else begin
                        e   = exp_q[d].pop_front();
                        due = due_q[d].pop_front();
                        if (rd_data[d] !== e || due != edge_cnt) begin
                            errors++;
                            $display("FAIL rd_data dut%0d got %h at edge %0d, required %h at edge %0d",
                                     d, rd_data[d], edge_cnt, e, due);
                        end
                    end
                    last_data[d] = rd_data[d];
                end else begin
                    if (due_q[d].size() > 0 && due_q[d][0] <= edge_cnt) begin
                        checks++;
                        errors++;
                        e   = exp_q[d].pop_front();
                        due = due_q[d].pop_front();
                        $display("FAIL missing_valid dut%0d got valid=%b at edge %0d, required valid with %h",
                                 d, rd_valid[d], edge_cnt, e);
                    end
                    checks++;
                    if (rd_data[d] !== last_data[d]) begin
                        errors++;
                        $display("FAIL data_hold dut%0d got %h, required %h",
                                 d, rd_data[d], last_data[d]);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, required finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int v0, v1;
        logic [AW-1:0] wa, ra;
        for (int d = 0; d < 2; d++) begin
            valid_seen[d] = 0;
            last_data[d]  = '0;
            since_rel[d]  = 0;
        end
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0; rst_n = 1'b0;

        // Reset, init length, request during init ignored.
        do_reset(3);
        count_busy(1'b1);

        // Read every address back to back: init image, out-of-range zeros.
        v0 = valid_seen[0]; v1 = valid_seen[1];
        for (int a = 0; a < 64; a++) drive(1'b0, '0, '0, 4'h0, 1'b1, AW'(a));
        drain();
        checks++;
        if (valid_seen[0] - v0 != 64 || valid_seen[1] - v1 != 64) begin
            errors++;
            $display("FAIL valid_count got %0d/%0d pulses, required 64/64",
                     valid_seen[0] - v0, valid_seen[1] - v1);
        end

        // Partial byte write then read.
        drive(1'b1, 6'd5, 32'h1111_1111, 4'hF, 1'b0, '0);
        drive(1'b1, 6'd5, 32'h2222_2222, 4'b0101, 1'b0, '0);
        drive(1'b0, '0, '0, 4'h0, 1'b1, 6'd5);
        drain();

        // Collision at addr 9, then follow-up read; also write-then-read.
        drive(1'b1, 6'd9, 32'hDEAD_BEEF, 4'hF, 1'b0, '0);
        drive(1'b1, 6'd9, 32'h0000_0000, 4'b0011, 1'b1, 6'd9);
        drive(1'b0, '0, '0, 4'h0, 1'b1, 6'd9);
        drive(1'b1, 6'd12, 32'hCAFE_F00D, 4'hF, 1'b0, '0);
        drive(1'b0, '0, '0, 4'h0, 1'b1, 6'd12);
        drive(1'b0, 6'd50, 32'h5555_5555, 4'hF, 1'b0, '0);
        drive(1'b1, 6'd50, 32'h5555_5555, 4'hF, 1'b1, 6'd50);
        drive(1'b0, '0, '0, 4'h0, 1'b1, 6'd50);
        drain();

        // Randomized traffic with frequent same-address collisions.
        for (int i = 0; i < 400; i++) begin
            wa = AW'($urandom_range(0, 63));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 63));
            drive(1'($urandom_range(0, 1)), wa, $urandom(), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) != 0), ra);
        end
        drain();

        // Reset mid-init restarts the full fill.
        do_reset(1);
        for (int i = 0; i < 20; i++) idle();
        do_reset(1);
        count_busy(1'b0);
        for (int a = 0; a < 16; a++) drive(1'b0, '0, '0, 4'h0, 1'b1, AW'(a));
        drain();

        // Reset while reads are in flight: outputs must clear, reads drop.
        drive(1'b1, 6'd7, 32'h7777_0000, 4'hC, 1'b1, 6'd2);
        drive(1'b0, '0, '0, 4'h0, 1'b1, 6'd7);
        do_reset(1);
        checks++;
        if (rd_valid[0] !== 1'b0 || rd_data[0] !== '0 || rd_valid[1] !== 1'b0 || rd_data[1] !== '0) begin
            errors++;
            $display("FAIL reset_flight got v=%b/%b d=%h/%h, required zeros",
                     rd_valid[0], rd_valid[1], rd_data[0], rd_data[1]);
        end
        count_busy(1'b0);
        for (int i = 0; i < 100; i++) begin
            wa = AW'($urandom_range(0, 63));
            drive(1'($urandom_range(0, 1)), wa, $urandom(), 4'($urandom_range(0, 15)),
                  1'b1, ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, 63)));
        end
        drain();

        for (int d = 0; d < 2; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin
                errors++;
                $display("FAIL queue_empty dut%0d got %0d pending, required 0", d, exp_q[d].size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
